// File: rtl/ama_riscv_defines.sv
// Shared definitions for the destination-register pipeline: RF address type,
// stage record layout and the register-pair helper.
package ama_riscv_defines;

    localparam int unsigned RF_ADDR_W = 5;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;

    localparam rf_addr_t RF_X0_ZERO = 5'd0;

    typedef struct packed {
        logic     valid;
        rf_addr_t rd;
        logic     rd_we;
        logic     rdp_we;
        logic     load;
        logic     mult;
    } rd_stage_t;

    localparam rd_stage_t RD_STAGE_BUBBLE = rd_stage_t'(10'd0);

    // Pair partner of an even destination register (rd+1 == rd with LSB set).
    function automatic rf_addr_t get_rdp(input rf_addr_t rd);
        return {rd[RF_ADDR_W-1:1], 1'b1};
    endfunction

endpackage

// File: rtl/ama_riscv_rd_stage.sv
// One pipeline stage record: hold, bubble insertion or load, cleared by reset.
import ama_riscv_defines::*;

module ama_riscv_rd_stage (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_hold,
    input  logic      i_bubble,
    input  rd_stage_t i_rec,
    output rd_stage_t o_rec
);

    rd_stage_t r_rec;

    // Stage register: hold has priority over bubble, bubble over load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rec <= RD_STAGE_BUBBLE;
        end else if (i_hold) begin
            r_rec <= r_rec;
        end else if (i_bubble) begin
            r_rec <= RD_STAGE_BUBBLE;
        end else begin
            r_rec <= i_rec;
        end
    end

    assign o_rec = r_rec;

endmodule

// File: rtl/ama_riscv_rd_pipe.sv
// Destination-register metadata pipeline EXE -> MEM -> WBK with stall, hazard
// and flush handling, RF write-port generation and retire counting.
import ama_riscv_defines::*;

module ama_riscv_rd_pipe (
    input  logic     clk,
    input  logic     rst_n,
    input  rf_addr_t rd_dec,
    input  logic     rd_we_dec,
    input  logic     rdp_we_dec,
    input  logic     load_dec,
    input  logic     mult_dec,
    input  logic     dc_stalled,
    input  logic     hazard_to_exe,
    input  logic     flush_dec,
    output rf_addr_t rd_mem,
    output rf_addr_t rd_wbk,
    output logic     rd_we_mem,
    output logic     rd_we_wbk,
    output logic     rdp_we_mem,
    output logic     rdp_we_wbk,
    output logic     load_inst_mem,
    output logic     load_inst_wbk,
    output logic     mult_inst_mem,
    output logic     rf_we,
    output rf_addr_t rf_waddr,
    output logic     rf_wep,
    output rf_addr_t rf_waddrp,
    output logic     pair_err,
    output logic [31:0] retire_cnt
);

    rd_stage_t   w_dec_rec;
    rd_stage_t   w_exe;
    rd_stage_t   w_mem;
    rd_stage_t   w_wbk;
    logic        w_rd_is_x0;
    logic        w_pair_odd;
    logic        w_exe_capture;
    logic        r_pair_err;
    logic [31:0] r_retire_cnt;

    assign w_rd_is_x0    = (rd_dec == RF_X0_ZERO);
    assign w_pair_odd    = rdp_we_dec & rd_dec[0];
    // hazard_to_exe outranks flush_dec, so a flush under hazard never captures
    assign w_exe_capture = ~dc_stalled & ~hazard_to_exe & ~flush_dec;

    // Sanitise decode metadata: x0 never writes, odd pair destinations are dropped.
    always_comb begin
        w_dec_rec        = RD_STAGE_BUBBLE;
        w_dec_rec.valid  = 1'b1;
        w_dec_rec.rd     = rd_dec;
        w_dec_rec.rd_we  = rd_we_dec & ~w_rd_is_x0;
        w_dec_rec.rdp_we = rdp_we_dec & ~w_rd_is_x0 & ~rd_dec[0];
        w_dec_rec.load   = load_dec;
        w_dec_rec.mult   = mult_dec;
    end

    ama_riscv_rd_stage u_stage_exe (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_hold   (dc_stalled | hazard_to_exe),
        .i_bubble (flush_dec),
        .i_rec    (w_dec_rec),
        .o_rec    (w_exe)
    );

    ama_riscv_rd_stage u_stage_mem (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_hold   (dc_stalled),
        .i_bubble (hazard_to_exe),
        .i_rec    (w_exe),
        .o_rec    (w_mem)
    );

    ama_riscv_rd_stage u_stage_wbk (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_hold   (dc_stalled),
        .i_bubble (1'b0),
        .i_rec    (w_mem),
        .o_rec    (w_wbk)
    );

    // Sticky illegal-pair flag, raised only when the odd pair actually enters EXE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pair_err <= 1'b0;
        end else if (w_exe_capture && w_pair_odd) begin
            r_pair_err <= 1'b1;
        end else begin
            r_pair_err <= r_pair_err;
        end
    end

    // Retire counter: a WBK record commits on its first unstalled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_cnt <= 32'd0;
        end else if (w_wbk.valid && !dc_stalled) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end else begin
            r_retire_cnt <= r_retire_cnt;
        end
    end

    assign rd_mem        = w_mem.rd;
    assign rd_we_mem     = w_mem.rd_we;
    assign rdp_we_mem    = w_mem.rdp_we;
    assign load_inst_mem = w_mem.load;
    assign mult_inst_mem = w_mem.mult;
    assign rd_wbk        = w_wbk.rd;
    assign rd_we_wbk     = w_wbk.rd_we;
    assign rdp_we_wbk    = w_wbk.rdp_we;
    assign load_inst_wbk = w_wbk.load;

    assign rf_we     = w_wbk.rd_we & ~dc_stalled;
    assign rf_waddr  = w_wbk.rd;
    assign rf_wep    = w_wbk.rdp_we & ~dc_stalled;
    // Pair address reads zero for a bubble so the port is quiet in reset.
    assign rf_waddrp = w_wbk.valid ? get_rdp(w_wbk.rd) : RF_X0_ZERO;

    assign pair_err   = r_pair_err;
    assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_ama_riscv_rd_pipe.sv
// Directed bench for the destination-register pipeline with hand-computed expectations.
import ama_riscv_defines::*;

module tb_ama_riscv_rd_pipe;

    logic        clk;
    logic        rst_n;
    rf_addr_t    rd_dec;
    logic        rd_we_dec;
    logic        rdp_we_dec;
    logic        load_dec;
    logic        mult_dec;
    logic        dc_stalled;
    logic        hazard_to_exe;
    logic        flush_dec;
    rf_addr_t    rd_mem;
    rf_addr_t    rd_wbk;
    logic        rd_we_mem;
    logic        rd_we_wbk;
    logic        rdp_we_mem;
    logic        rdp_we_wbk;
    logic        load_inst_mem;
    logic        load_inst_wbk;
    logic        mult_inst_mem;
    logic        rf_we;
    rf_addr_t    rf_waddr;
    logic        rf_wep;
    rf_addr_t    rf_waddrp;
    logic        pair_err;
    logic [31:0] retire_cnt;

    int n_chk;
    int n_pass;

    ama_riscv_rd_pipe dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_dec        (rd_dec),
        .rd_we_dec     (rd_we_dec),
        .rdp_we_dec    (rdp_we_dec),
        .load_dec      (load_dec),
        .mult_dec      (mult_dec),
        .dc_stalled    (dc_stalled),
        .hazard_to_exe (hazard_to_exe),
        .flush_dec     (flush_dec),
        .rd_mem        (rd_mem),
        .rd_wbk        (rd_wbk),
        .rd_we_mem     (rd_we_mem),
        .rd_we_wbk     (rd_we_wbk),
        .rdp_we_mem    (rdp_we_mem),
        .rdp_we_wbk    (rdp_we_wbk),
        .load_inst_mem (load_inst_mem),
        .load_inst_wbk (load_inst_wbk),
        .mult_inst_mem (mult_inst_mem),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wep        (rf_wep),
        .rf_waddrp     (rf_waddrp),
        .pair_err      (pair_err),
        .retire_cnt    (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Idle decode injects bubbles so only issued instructions retire.
    task automatic set_idle();
        rd_dec        = 5'd0;
        rd_we_dec     = 1'b0;
        rdp_we_dec    = 1'b0;
        load_dec      = 1'b0;
        mult_dec      = 1'b0;
        hazard_to_exe = 1'b0;
        flush_dec     = 1'b1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic we, input logic pwe,
                         input logic ld, input logic ml);
        rd_dec        = rd;
        rd_we_dec     = we;
        rdp_we_dec    = pwe;
        load_dec      = ld;
        mult_dec      = ml;
        hazard_to_exe = 1'b0;
        flush_dec     = 1'b0;
        step();
        set_idle();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_mem"},     32'(rd_mem),        32'd0);
        chk({tag, "_rd_wbk"},     32'(rd_wbk),        32'd0);
        chk({tag, "_rd_we_mem"},  32'(rd_we_mem),     32'd0);
        chk({tag, "_rd_we_wbk"},  32'(rd_we_wbk),     32'd0);
        chk({tag, "_rdp_we_mem"}, 32'(rdp_we_mem),    32'd0);
        chk({tag, "_load_mem"},   32'(load_inst_mem), 32'd0);
        chk({tag, "_mult_mem"},   32'(mult_inst_mem), 32'd0);
        chk({tag, "_rf_we"},      32'(rf_we),         32'd0);
        chk({tag, "_rf_wep"},     32'(rf_wep),        32'd0);
        chk({tag, "_rf_waddrp"},  32'(rf_waddrp),     32'd0);
        chk({tag, "_pair_err"},   32'(pair_err),      32'd0);
        chk({tag, "_retire"},     retire_cnt,         32'd0);
    endtask

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        rst_n      = 1'b0;
        dc_stalled = 1'b0;
        set_idle();
        #12;
        chk_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Plain write to x5
        issue(5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("a_rd_mem_early", 32'(rd_mem), 32'd0);
        step();
        chk("a_rd_mem", 32'(rd_mem), 32'd5);
        chk("a_rd_we_mem", 32'(rd_we_mem), 32'd1);
        chk("a_rf_we_early", 32'(rf_we), 32'd0);
        step();
        chk("a_rf_we", 32'(rf_we), 32'd1);
        chk("a_rf_waddr", 32'(rf_waddr), 32'd5);
        chk("a_retire_pre", retire_cnt, 32'd0);
        step();
        chk("a_retire", retire_cnt, 32'd1);
        chk("a_rf_we_after", 32'(rf_we), 32'd0);

        // Write to x0 is suppressed but still retires
        issue(5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk("b_rd_we_mem", 32'(rd_we_mem), 32'd0);
        step();
        chk("b_rf_we", 32'(rf_we), 32'd0);
        step();
        chk("b_rf_we_after", 32'(rf_we), 32'd0);
        chk("b_retire", retire_cnt, 32'd2);

        // Legal pair x6/x7
        issue(5'd6, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        chk("c_rdp_we_mem", 32'(rdp_we_mem), 32'd1);
        step();
        chk("c_rf_wep", 32'(rf_wep), 32'd1);
        chk("c_rf_waddrp", 32'(rf_waddrp), 32'd7);
        chk("c_rf_we", 32'(rf_we), 32'd0);
        step();
        chk("c_retire", retire_cnt, 32'd3);
        chk("c_pair_err_clean", 32'(pair_err), 32'd0);

        // Illegal odd pair x7
        issue(5'd7, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("c_pair_err_set", 32'(pair_err), 32'd1);
        step();
        chk("c_odd_rdp_we_mem", 32'(rdp_we_mem), 32'd0);
        step();
        chk("c_odd_rf_wep", 32'(rf_wep), 32'd0);
        step();
        chk("c_pair_err_sticky", 32'(pair_err), 32'd1);
        chk("c_odd_retire", retire_cnt, 32'd4);

        // Load to x3 stalled in WBK for 4 cycles
        issue(5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        chk("d_load_mem", 32'(load_inst_mem), 32'd1);
        step();
        dc_stalled = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("d_stall%0d_rf_we", i), 32'(rf_we), 32'd0);
            chk($sformatf("d_stall%0d_load_wbk", i), 32'(load_inst_wbk), 32'd1);
            chk($sformatf("d_stall%0d_retire", i), retire_cnt, 32'd4);
            step();
        end
        dc_stalled = 1'b0;
        #1;
        chk("d_rf_we", 32'(rf_we), 32'd1);
        chk("d_rf_waddr", 32'(rf_waddr), 32'd3);
        chk("d_load_wbk", 32'(load_inst_wbk), 32'd1);
        step();
        chk("d_rf_we_once", 32'(rf_we), 32'd0);
        chk("d_retire", retire_cnt, 32'd5);

        // Hazard and flush together: hazard wins
        issue(5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        rd_dec        = 5'd12;
        rd_we_dec     = 1'b1;
        hazard_to_exe = 1'b1;
        flush_dec     = 1'b1;
        step();
        chk("e_mem_bubble_we", 32'(rd_we_mem), 32'd0);
        chk("e_mem_bubble_rd", 32'(rd_mem), 32'd0);
        chk("e_wbk_rd", 32'(rd_wbk), 32'd8);
        chk("e_wbk_rf_we", 32'(rf_we), 32'd1);
        set_idle();
        step();
        chk("e_exe_kept_rd", 32'(rd_mem), 32'd9);
        chk("e_exe_kept_we", 32'(rd_we_mem), 32'd1);
        chk("e_retire_mid", retire_cnt, 32'd6);
        step();
        chk("e_rf_waddr", 32'(rf_waddr), 32'd9);
        chk("e_rf_we", 32'(rf_we), 32'd1);
        step();
        chk("e_retire", retire_cnt, 32'd7);
        chk("e_rd_mem_no12", 32'(rd_mem), 32'd0);
        chk("e_pair_err_sticky", 32'(pair_err), 32'd1);

        // Reset mid-stall with three valid records
        issue(5'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("f_pre_rd_wbk", 32'(rd_wbk), 32'd1);
        chk("f_pre_rd_mem", 32'(rd_mem), 32'd2);
        chk("f_pre_rf_we", 32'(rf_we), 32'd1);
        dc_stalled = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("f_rst");
        dc_stalled = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("f_post%0d_rf_we", i), 32'(rf_we), 32'd0);
        end
        chk("f_post_retire", retire_cnt, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
